regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the next core generation (superscalar/out-of-order completion).
- Decode/issue reserves destination registers through the alloc port; writeback ports complete them.
- Read ports return data plus a busy flag so issue logic can stall on RAW hazards.
- Replaces the single-write, unscored register file.

---
 rtl/regfile_mp_pkg.sv | 20 ++
 rtl/regfile_mp_sb.sv | 110 +++++++++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared core constants and read-path bundle types.
// Exports RF_XLEN/RF_NREGS/RF_AW, reg_addr_t, rd_req_t, rd_rsp_t.
package regfile_mp_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t addr;
  } rd_req_t;

  typedef struct packed {
    logic [RF_XLEN-1:0] data;
    logic               busy;
  } rd_rsp_t;

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-write scoreboard: per-register counters, alloc_ready,
// flush and sticky sb_err. Outputs busy (pre-edge) and busy_post
// (count after same-cycle completions).
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int NWR      = 2,
  parameter int MAX_PEND = 3,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_valid,
  input  logic [AW-1:0]     alloc_addr,
  output logic              alloc_ready,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic [NREGS-1:0]  busy_post,
  output logic              sb_err
);

  logic [CW-1:0] cnt_q [NREGS];
  logic [CW-1:0] cnt_d [NREGS];
  int            dec   [NREGS];
  logic          uflow;
  logic          sb_err_q;
  logic          sb_err_d;
  logic          a_zero;

  assign a_zero = (ZERO_REG != 0) && (alloc_addr == '0);

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = 0;
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
          dec[r] = dec[r] + 1;
        end
      end
    end
    if (ZERO_REG != 0) begin
      dec[0] = 0;
    end
  end

  // Completions landing this cycle free their slots for the alloc.
  always_comb begin
    alloc_ready = 1'b1;
    if (!a_zero) begin
      alloc_ready =
        (int'(cnt_q[alloc_addr]) - dec[alloc_addr]) < MAX_PEND;
    end
  end

  always_comb begin
    int nxt;
    int inc;
    uflow = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      inc = 0;
      if (alloc_valid && alloc_ready && !a_zero &&
          alloc_addr == AW'(r)) begin
        inc = 1;
      end
      nxt = int'(cnt_q[r]) + inc - dec[r];
      if (nxt < 0) begin
        uflow = 1'b1;
        nxt   = 0;
      end
      if (flush) begin
        nxt = 0;
      end
      cnt_d[r] = nxt[CW-1:0];
    end
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy[r]      = cnt_q[r] != '0;
      busy_post[r] = (int'(cnt_q[r]) - dec[r]) > 0;
    end
    if (ZERO_REG != 0) begin
      busy[0]      = 1'b0;
      busy_post[0] = 1'b0;
    end
  end

  assign sb_err_d = sb_err_q | uflow;
  assign sb_err   = sb_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_err_q <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      sb_err_q <= sb_err_d;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard.
// Ports: clock/reset_n, NRD read ports (rd_addr/rd_data/rd_busy),
// alloc_valid/addr/ready, NWR write ports, flush, sticky sb_err.
// REGFILE_MP_FWD_EN: same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int MAX_PEND = 3,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  output logic                alloc_ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                flush,
  output logic                sb_err
);

  logic [XLEN-1:0]  data_q [NREGS];
  logic [XLEN-1:0]  data_d [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_post;

  regfile_mp_sb #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .MAX_PEND (MAX_PEND),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock       (clock),
    .reset_n     (reset_n),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .busy        (busy),
    .busy_post   (busy_post),
    .sb_err      (sb_err)
  );

  // Later ports overwrite earlier ones: highest index wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      data_d[r] = data_q[r];
    end
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) begin
        data_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
    end
    if (ZERO_REG != 0) begin
      data_d[0] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= data_d[r];
      end
    end
  end

`ifndef REGFILE_MP_FWD_EN
  logic unused_busy_post;
  assign unused_busy_post = ^busy_post;
`endif

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rb;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra   = rd_addr[i*AW +: AW];
      rdat = data_q[ra];
      rb   = busy[ra];
`ifdef REGFILE_MP_FWD_EN
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == ra) begin
          rdat = wr_data[w*XLEN +: XLEN];
        end
      end
      rb = busy_post[ra];
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        rdat = '0;
        rb   = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = rdat;
      rd_busy[i]              = rb;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters).
// Checks reset, scoreboard, write priority, flush, r0, forwarding.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int XL = 32;

  logic          clock;
  logic          reset_n;
  logic [2*AW-1:0] rd_addr;
  logic [2*XL-1:0] rd_data;
  logic [1:0]    rd_busy;
  logic          alloc_valid;
  logic [AW-1:0] alloc_addr;
  logic          alloc_ready;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XL-1:0] wr_data;
  logic          flush;
  logic          sb_err;

  int n_cmp;
  int n_bad;

  regfile_mp dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flush       (flush),
    .sb_err      (sb_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0,
                    input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    rd_addr = '0;
    alloc_valid = 1'b0;
    alloc_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    flush = 1'b0;
    #22;
    reset_n = 1'b1;
    tick();

    // Reset state
    for (int r = 0; r < 32; r += 2) begin
      rd(AW'(r), AW'(r + 1));
      check("rst_d0", rd_data[31:0], 32'h0);
      check("rst_d1", rd_data[63:32], 32'h0);
      check("rst_b", {30'h0, rd_busy}, 32'h0);
    end
    check("rst_rdy", {31'h0, alloc_ready}, 32'h1);
    check("rst_err", {31'h0, sb_err}, 32'h0);

    // Saturate r5
    rd(5'd5, 5'd0);
    alloc_valid = 1'b1;
    alloc_addr = 5'd5;
    #1;
    check("a5_rdy0", {31'h0, alloc_ready}, 32'h1);
    tick();
    check("a5_rdy1", {31'h0, alloc_ready}, 32'h1);
    check("a5_busy", {31'h0, rd_busy[0]}, 32'h1);
    tick();
    check("a5_rdy2", {31'h0, alloc_ready}, 32'h1);
    tick();
    check("a5_full", {31'h0, alloc_ready}, 32'h0);
    tick();
    check("a5_hold", {31'h0, alloc_ready}, 32'h0);
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'h0000_0055};
    #1;
    check("a5_net", {31'h0, alloc_ready}, 32'h1);
    tick();
    wr_en = 2'b00;
    #1;
    check("a5_still3", {31'h0, alloc_ready}, 32'h0);
    check("a5_data", rd_data[31:0], 32'h55);
    alloc_valid = 1'b0;
    wr_en = 2'b11;
    wr_addr = {5'd5, 5'd5};
    tick();
    wr_en = 2'b00;
    #1;
    check("a5_cnt1", {31'h0, rd_busy[0]}, 32'h1);
    wr_en = 2'b01;
    tick();
    wr_en = 2'b00;
    #1;
    check("a5_cnt0", {31'h0, rd_busy[0]}, 32'h0);
    check("a5_err", {31'h0, sb_err}, 32'h0);

    // r7: two writers, one cycle
    rd(5'd7, 5'd0);
    alloc_valid = 1'b1;
    alloc_addr = 5'd7;
    tick();
    tick();
    alloc_valid = 1'b0;
    #1;
    check("r7_busy", {31'h0, rd_busy[0]}, 32'h1);
    wr_en = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h5555_1111, 32'hAAAA_0000};
    #1;
`ifdef REGFILE_MP_FWD_EN
    check("r7_fwd_d", rd_data[31:0], 32'h5555_1111);
    check("r7_fwd_b", {31'h0, rd_busy[0]}, 32'h0);
`else
    check("r7_old_d", rd_data[31:0], 32'h0);
    check("r7_old_b", {31'h0, rd_busy[0]}, 32'h1);
`endif
    tick();
    wr_en = 2'b00;
    #1;
    check("r7_data", rd_data[31:0], 32'h5555_1111);
    check("r7_busy0", {31'h0, rd_busy[0]}, 32'h0);
    check("r7_err", {31'h0, sb_err}, 32'h0);

    // r0 ignores writes and allocs
    rd(5'd0, 5'd0);
    alloc_valid = 1'b1;
    alloc_addr = 5'd0;
    wr_en = 2'b10;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'hDEAD_BEEF, 32'h0};
    #1;
    check("r0_rdy", {31'h0, alloc_ready}, 32'h1);
    check("r0_fwd", rd_data[31:0], 32'h0);
    tick();
    alloc_valid = 1'b0;
    wr_en = 2'b00;
    #1;
    check("r0_data", rd_data[63:32], 32'h0);
    check("r0_busy", {30'h0, rd_busy}, 32'h0);
    check("r0_err", {31'h0, sb_err}, 32'h0);

    // r3: flush overrides alloc
    rd(5'd3, 5'd0);
    alloc_valid = 1'b1;
    alloc_addr = 5'd3;
    tick();
    tick();
    check("r3_busy", {31'h0, rd_busy[0]}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("r3_flush", {31'h0, rd_busy[0]}, 32'h0);
    check("r3_rdy0", {31'h0, alloc_ready}, 32'h1);
    tick();
    check("r3_rdy1", {31'h0, alloc_ready}, 32'h1);
    tick();
    check("r3_rdy2", {31'h0, alloc_ready}, 32'h1);
    tick();
    check("r3_full", {31'h0, alloc_ready}, 32'h0);
    alloc_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("r3_clr", {31'h0, rd_busy[0]}, 32'h0);

    // Underflow on r9
    rd(5'd9, 5'd0);
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd9};
    wr_data = {32'h0, 32'h0000_9999};
    #1;
    check("r9_pre", {31'h0, sb_err}, 32'h0);
    tick();
    wr_en = 2'b00;
    #1;
    check("r9_err", {31'h0, sb_err}, 32'h1);
    check("r9_data", rd_data[31:0], 32'h9999);
    check("r9_busy", {31'h0, rd_busy[0]}, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("r9_stky", {31'h0, sb_err}, 32'h1);

    // Forwarding vs. next-cycle visibility on r4
    rd(5'd0, 5'd4);
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd4};
    wr_data = {32'h0, 32'h0000_1234};
    #1;
`ifdef REGFILE_MP_FWD_EN
    check("r4_same", rd_data[63:32], 32'h1234);
`else
    check("r4_same", rd_data[63:32], 32'h0);
`endif
    tick();
    wr_en = 2'b00;
    #1;
    check("r4_next", rd_data[63:32], 32'h1234);

    // Async reset mid-operation
    alloc_valid = 1'b1;
    alloc_addr = 5'd2;
    tick();
    alloc_valid = 1'b0;
    rd(5'd2, 5'd7);
    check("mr_busy", {31'h0, rd_busy[0]}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_b0", {31'h0, rd_busy[0]}, 32'h0);
    check("mr_d7", rd_data[63:32], 32'h0);
    check("mr_err", {31'h0, sb_err}, 32'h0);
    #2;
    reset_n = 1'b1;
    tick();
    check("mr_rdy", {31'h0, alloc_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
